cap_prop_stim_driver: RTL and testbench

- Sequential initiator that generates capability-property test vectors (base, len, addr, new_len) and drives them to a downstream property checker.
- The checker is the existing bank of combinational prop_* checker modules, wrapped behind a 1-cycle result register; it returns one ok bit per vector.
- The block tallies passes and failures and latches the first failing vector for debug.
- Sits in the formal/simulation harness beside the property checkers; usable standalone in simulation or as an FPGA self-test.

---
 rtl/cap_prop_pkg.sv | 44 ++++
 rtl/cap_prop_lfsr64.sv | 32 +++
 rtl/cap_prop_stim_driver.sv | 175 +++++++++++++++++
 tb/tb_cap_prop_stim_driver.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cap_prop_pkg.sv
// Shared types and constants for the capability-property stimulus driver.
// Holds the vector struct, FSM states, corner-case table and LFSR taps.
package cap_prop_pkg;

  localparam int CAP_W       = 64;
  localparam int NUM_CORNERS = 8;

  // Galois taps for x^64 + x^63 + x^61 + x^60 + 1 on a right-shifting register
  localparam logic [CAP_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef struct packed {
    logic [CAP_W-1:0] base;
    logic [CAP_W-1:0] len;
    logic [CAP_W-1:0] addr;
    logic [CAP_W-1:0] new_len;
  } cap_vec_t;

  typedef enum logic [2:0] {
    IDLE,
    CORNER,
    RANDOM,
    WAIT_RES,
    DONE
  } state_t;

  localparam cap_vec_t CORNER_VECS [NUM_CORNERS] = '{
    '{base: 64'h0, len: 64'h0, addr: 64'h0, new_len: 64'h0},
    '{base: 64'h0, len: 64'hFFFF_FFFF_FFFF_FFFF, addr: 64'h0, new_len: 64'h1},
    '{base: 64'h1000, len: 64'h1000, addr: 64'h1FFF, new_len: 64'h1},
    '{base: 64'hFFFF_FFFF_FFFF_F000, len: 64'h1000,
      addr: 64'hFFFF_FFFF_FFFF_F000, new_len: 64'h1000},
    '{base: 64'hFFF, len: 64'h1_0001, addr: 64'h1000, new_len: 64'hFFF},
    '{base: 64'h0000_0100_0000_0000, len: 64'h0000_0100_0000_0000,
      addr: 64'h0000_01FF_FFFF_FFFF, new_len: 64'h0000_0080_0000_0000},
    '{base: 64'h7, len: 64'h3FFF, addr: 64'h7, new_len: 64'h3FFF},
    '{base: 64'hFFFF_FFFF_FFFF_FFFF, len: 64'h1,
      addr: 64'hFFFF_FFFF_FFFF_FFFF, new_len: 64'h0}
  };

  function automatic logic [CAP_W-1:0] ror64(input logic [CAP_W-1:0] v, input int k);
    return (v >> k) | (v << (CAP_W - k));
  endfunction

endpackage

// File: rtl/cap_prop_lfsr64.sv
// 64-bit Galois LFSR plus the mapping from its state to a random test vector.
// The vector is derived combinationally, so it is stable until the next step.
module cap_prop_lfsr64
  import cap_prop_pkg::*;
#(
  parameter logic [CAP_W-1:0] SEED = 64'hACE1_0000_0000_0001
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  output logic [CAP_W-1:0] s,
  output cap_vec_t         vec
);

  always_ff @(posedge clk) begin
    if (load) begin
      s <= SEED;
    end else if (step) begin
      s <= s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    end
  end

  // Shifting by low state bits spreads lengths across all magnitudes
  always_comb begin
    vec         = '0;
    vec.base    = s;
    vec.len     = ror64(s, 17) >> s[5:0];
    vec.addr    = s + (ror64(s, 31) & vec.len);
    vec.new_len = ror64(s, 43) >> s[11:6];
  end

endmodule

// File: rtl/cap_prop_stim_driver.sv
// Issues corner-table then pseudo-random capability vectors to a property checker,
// one at a time, tallying pass/fail results and latching the first failing vector.
module cap_prop_stim_driver
  import cap_prop_pkg::*;
#(
  parameter int unsigned      ADDR_W    = 64,
  parameter int unsigned      NUM_RAND  = 1024,
  parameter logic [CAP_W-1:0] LFSR_SEED = 64'hACE1_0000_0000_0001,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic [ADDR_W-1:0] vec_base,
  output logic [ADDR_W-1:0] vec_len,
  output logic [ADDR_W-1:0] vec_addr,
  output logic [ADDR_W-1:0] vec_new_len,
  input  logic              res_valid,
  input  logic              res_ok,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              fail_seen,
  output logic [ADDR_W-1:0] fail_base,
  output logic [ADDR_W-1:0] fail_len,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W-1:0] fail_new_len
);

  state_t           state;
  state_t           state_next;
  logic [2:0]       index;
  logic [31:0]      rand_cnt;
  logic             in_rand;
  logic             hs;
  logic             res_take;
  logic             run_start;
  logic             rand_more;
  logic             last_corner;
  logic [CAP_W-1:0] lfsr_s;
  logic             lfsr_zero;
  cap_vec_t         rand_vec;
  cap_vec_t         cur_vec;
  cap_vec_t         shadow;
  cap_vec_t         fail_vec;

  // An all-zero state would lock the LFSR; reload the seed should it ever occur
  assign lfsr_zero = (lfsr_s == '0);

  cap_prop_lfsr64 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (CLK),
    .load (!RST_N || lfsr_zero),
    .step (hs && (state == RANDOM)),
    .s    (lfsr_s),
    .vec  (rand_vec)
  );

  assign last_corner = (index == 3'(NUM_CORNERS - 1));
  assign rand_more   = in_rand ? ((rand_cnt + 32'd1) < NUM_RAND) : (NUM_RAND != 0);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    hs         = 1'b0;
    res_take   = 1'b0;
    run_start  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = CORNER;
          run_start  = 1'b1;
        end
      end
      CORNER, RANDOM: begin
        if (vec_ready) begin
          state_next = WAIT_RES;
          hs         = 1'b1;
        end
      end
      WAIT_RES: begin
        if (res_valid) begin
          res_take = 1'b1;
          if (!in_rand && !last_corner) begin
            state_next = CORNER;
          end else if (rand_more) begin
            state_next = RANDOM;
          end else begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cur_vec = '0;
    if (state == CORNER) begin
      cur_vec = CORNER_VECS[index];
    end else if (state == RANDOM) begin
      cur_vec = rand_vec;
    end
  end

  // Run bookkeeping: progress through the tables, tallies and first-failure capture
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      index     <= '0;
      rand_cnt  <= '0;
      in_rand   <= 1'b0;
      shadow    <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      fail_seen <= 1'b0;
      fail_vec  <= '0;
    end else begin
      if (run_start) begin
        index     <= '0;
        rand_cnt  <= '0;
        in_rand   <= 1'b0;
        pass_cnt  <= '0;
        fail_cnt  <= '0;
        fail_seen <= 1'b0;
        fail_vec  <= '0;
      end
      if (hs) begin
        shadow <= cur_vec;
      end
      if (res_take) begin
        if (res_ok) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
          if (!fail_seen) begin
            fail_seen <= 1'b1;
            fail_vec  <= shadow;
          end
        end
        if (!in_rand && !last_corner) begin
          index <= index + 3'd1;
        end else if (!in_rand) begin
          in_rand <= 1'b1;
          index   <= '0;
        end else begin
          rand_cnt <= rand_cnt + 32'd1;
        end
      end
    end
  end

  assign busy         = (state == CORNER) || (state == RANDOM) || (state == WAIT_RES);
  assign done         = (state == DONE);
  assign vec_valid    = (state == CORNER) || (state == RANDOM);
  assign vec_base     = cur_vec.base;
  assign vec_len      = cur_vec.len;
  assign vec_addr     = cur_vec.addr;
  assign vec_new_len  = cur_vec.new_len;
  assign fail_base    = fail_vec.base;
  assign fail_len     = fail_vec.len;
  assign fail_addr    = fail_vec.addr;
  assign fail_new_len = fail_vec.new_len;

endmodule

// File: tb/tb_cap_prop_stim_driver.sv
// Directed bench for cap_prop_stim_driver with a responding checker model
// and a scoreboard of expected vectors built from a reference model.
module tb_cap_prop_stim_driver;

  typedef struct packed {
    logic [63:0] base;
    logic [63:0] len;
    logic [63:0] addr;
    logic [63:0] new_len;
  } tb_vec_t;

  localparam logic [63:0] SEED = 64'hACE1_0000_0000_0001;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic        busy;
  logic        done;
  logic        vec_valid;
  logic        vec_ready;
  logic [63:0] vec_base;
  logic [63:0] vec_len;
  logic [63:0] vec_addr;
  logic [63:0] vec_new_len;
  logic        res_valid;
  logic        res_ok;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic        fail_seen;
  logic [63:0] fail_base;
  logic [63:0] fail_len;
  logic [63:0] fail_addr;
  logic [63:0] fail_new_len;

  int          total = 0;
  int          bad = 0;
  tb_vec_t     got_q[$];
  tb_vec_t     exp_q[$];
  logic [63:0] mdl_lfsr;
  logic [63:0] fail_mask;
  logic        inj_valid;
  logic        inj_ok;
  logic        pend;
  logic        pend_ok;
  int          hs_count;

  cap_prop_stim_driver #(
    .ADDR_W    (64),
    .NUM_RAND  (4),
    .LFSR_SEED (SEED),
    .CNT_W     (16)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .vec_base     (vec_base),
    .vec_len      (vec_len),
    .vec_addr     (vec_addr),
    .vec_new_len  (vec_new_len),
    .res_valid    (res_valid),
    .res_ok       (res_ok),
    .pass_cnt     (pass_cnt),
    .fail_cnt     (fail_cnt),
    .fail_seen    (fail_seen),
    .fail_base    (fail_base),
    .fail_len     (fail_len),
    .fail_addr    (fail_addr),
    .fail_new_len (fail_new_len)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [63:0] rot(input logic [63:0] v, input int k);
    return (v >> k) | (v << (64 - k));
  endfunction

  function automatic logic [63:0] lfsr_adv(input logic [63:0] s);
    logic [63:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 64'hD800_0000_0000_0000;
    return n;
  endfunction

  function automatic tb_vec_t rand_model(input logic [63:0] s);
    tb_vec_t v;
    v.base    = s;
    v.len     = rot(s, 17) >> s[5:0];
    v.addr    = s + (rot(s, 31) & v.len);
    v.new_len = rot(s, 43) >> s[11:6];
    return v;
  endfunction

  function automatic tb_vec_t corner(input int i);
    tb_vec_t v;
    case (i)
      0: v = {64'h0, 64'h0, 64'h0, 64'h0};
      1: v = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1};
      2: v = {64'h1000, 64'h1000, 64'h1FFF, 64'h1};
      3: v = {64'hFFFF_FFFF_FFFF_F000, 64'h1000, 64'hFFFF_FFFF_FFFF_F000, 64'h1000};
      4: v = {64'hFFF, 64'h1_0001, 64'h1000, 64'hFFF};
      5: v = {64'h100_0000_0000, 64'h100_0000_0000, 64'h1FF_FFFF_FFFF, 64'h80_0000_0000};
      6: v = {64'h7, 64'h3FFF, 64'h7, 64'h3FFF};
      default: v = {64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    endcase
    return v;
  endfunction

  // Checker model: one result per accepted vector, presented on the following cycle
  initial begin
    res_valid = 1'b0;
    res_ok    = 1'b0;
    pend      = 1'b0;
    pend_ok   = 1'b0;
    hs_count  = 0;
    forever begin
      @(negedge CLK);
      #1;
      res_valid = pend | inj_valid;
      res_ok    = pend ? pend_ok : inj_ok;
      pend      = 1'b0;
      if (start) hs_count = 0;
      if (RST_N && vec_valid && vec_ready) begin
        got_q.push_back({vec_base, vec_len, vec_addr, vec_new_len});
        pend    = 1'b1;
        pend_ok = (hs_count < 64) ? !fail_mask[hs_count] : 1'b1;
        hs_count++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic push_run_expect();
    for (int i = 0; i < 8; i++) exp_q.push_back(corner(i));
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(rand_model(mdl_lfsr));
      mdl_lfsr = lfsr_adv(mdl_lfsr);
    end
  endtask

  task automatic check_vectors(input string tag, input int off, input int n);
    tb_vec_t e;
    tb_vec_t g;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      g = (off + i < got_q.size()) ? got_q[off + i] : '0;
      checkOutput($sformatf("%s_v%0d_base", tag, i), g.base, e.base);
      checkOutput($sformatf("%s_v%0d_len", tag, i), g.len, e.len);
      checkOutput($sformatf("%s_v%0d_addr", tag, i), g.addr, e.addr);
      checkOutput($sformatf("%s_v%0d_new_len", tag, i), g.new_len, e.new_len);
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (!done && n < max_cyc) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("run_done", 64'(done), 64'd1);
  endtask

  initial begin
    int      off1;
    int      off2;
    int      off3;
    int      off4;
    int      off5;
    int      n;
    logic    stable;
    tb_vec_t c5;
    tb_vec_t a;
    tb_vec_t b;

    RST_N     = 1'b0;
    start     = 1'b0;
    vec_ready = 1'b1;
    inj_valid = 1'b0;
    inj_ok    = 1'b0;
    fail_mask = '0;
    mdl_lfsr  = SEED;
    $display("[TB] reset");
    repeat (3) @(negedge CLK);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_vec_valid", 64'(vec_valid), 64'd0);
    checkOutput("rst_vec_len", vec_len, 64'd0);
    checkOutput("rst_pass_cnt", 64'(pass_cnt), 64'd0);
    checkOutput("rst_fail_cnt", 64'(fail_cnt), 64'd0);
    checkOutput("rst_fail_seen", 64'(fail_seen), 64'd0);
    checkOutput("rst_fail_base", fail_base, 64'd0);
    RST_N = 1'b1;

    $display("[TB] stray results while idle");
    @(negedge CLK);
    inj_valid = 1'b1;
    inj_ok    = 1'b1;
    @(negedge CLK);
    inj_ok    = 1'b0;
    @(negedge CLK);
    inj_valid = 1'b0;
    @(negedge CLK);
    checkOutput("idle_res_pass", 64'(pass_cnt), 64'd0);
    checkOutput("idle_res_fail", 64'(fail_cnt), 64'd0);
    checkOutput("idle_res_busy", 64'(busy), 64'd0);

    $display("[TB] run 1: all pass");
    off1 = got_q.size();
    push_run_expect();
    applyStimulus();
    checkOutput("run1_busy", 64'(busy), 64'd1);
    wait_done(500);
    @(negedge CLK);
    checkOutput("run1_count", 64'(got_q.size() - off1), 64'd12);
    check_vectors("run1", off1, 12);
    checkOutput("run1_pass", 64'(pass_cnt), 64'd12);
    checkOutput("run1_fail", 64'(fail_cnt), 64'd0);
    checkOutput("run1_done", 64'(done), 64'd1);
    checkOutput("run1_busy_end", 64'(busy), 64'd0);
    checkOutput("run1_fail_seen", 64'(fail_seen), 64'd0);

    $display("[TB] run 2: failures on results 3 and 9");
    fail_mask = 64'h0104;
    off2 = got_q.size();
    push_run_expect();
    applyStimulus();
    checkOutput("run2_clr_pass", 64'(pass_cnt), 64'd0);
    checkOutput("run2_done_low", 64'(done), 64'd0);
    wait_done(500);
    @(negedge CLK);
    checkOutput("run2_count", 64'(got_q.size() - off2), 64'd12);
    check_vectors("run2", off2, 12);
    checkOutput("run2_pass", 64'(pass_cnt), 64'd10);
    checkOutput("run2_fail", 64'(fail_cnt), 64'd2);
    checkOutput("run2_fail_seen", 64'(fail_seen), 64'd1);
    checkOutput("run2_fail_base", fail_base, 64'h1000);
    checkOutput("run2_fail_len", fail_len, 64'h1000);
    checkOutput("run2_fail_addr", fail_addr, 64'h1FFF);
    checkOutput("run2_fail_new_len", fail_new_len, 64'h1);
    for (int k = 0; k < 4; k++) begin
      a = (off1 + 8 + k < got_q.size()) ? got_q[off1 + 8 + k] : '0;
      b = (off2 + 8 + k < got_q.size()) ? got_q[off2 + 8 + k] : '0;
      checkOutput($sformatf("run2_rand%0d_new", k), 64'(a.base != b.base), 64'd1);
    end

    $display("[TB] run 3: stall at corner 5");
    fail_mask = '0;
    c5 = corner(5);
    off3 = got_q.size();
    push_run_expect();
    applyStimulus();
    n = 0;
    while (!(vec_valid && vec_base === c5.base) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    vec_ready = 1'b0;
    checkOutput("run3_reached_c5", 64'(vec_valid && vec_base === c5.base), 64'd1);
    checkOutput("run3_clr_fail_seen", 64'(fail_seen), 64'd0);
    checkOutput("run3_clr_fail_cnt", 64'(fail_cnt), 64'd0);
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      if (c == 10) begin
        inj_valid = 1'b1;
        inj_ok    = 1'b1;
      end
      if (c == 11) inj_valid = 1'b0;
      if (c == 20) start = 1'b1;
      if (c == 21) start = 1'b0;
      if (!(vec_valid === 1'b1 && {vec_base, vec_len, vec_addr, vec_new_len} === c5))
        stable = 1'b0;
    end
    checkOutput("run3_stall_stable", 64'(stable), 64'd1);
    checkOutput("run3_stall_len", vec_len, c5.len);
    checkOutput("run3_stall_addr", vec_addr, c5.addr);
    checkOutput("run3_stall_new_len", vec_new_len, c5.new_len);
    checkOutput("run3_stall_pass", 64'(pass_cnt), 64'd5);
    checkOutput("run3_stall_fail", 64'(fail_cnt), 64'd0);
    checkOutput("run3_stall_busy", 64'(busy), 64'd1);
    vec_ready = 1'b1;
    wait_done(500);
    @(negedge CLK);
    checkOutput("run3_count", 64'(got_q.size() - off3), 64'd12);
    check_vectors("run3", off3, 12);
    checkOutput("run3_pass", 64'(pass_cnt), 64'd12);

    $display("[TB] run 4: reset during random vector 2");
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    mdl_lfsr = SEED;
    off4 = got_q.size();
    push_run_expect();
    applyStimulus();
    n = 0;
    while (!(got_q.size() == off4 + 11 && !vec_valid && busy) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("run4_reached_wait", 64'(got_q.size() == off4 + 11 && !vec_valid && busy), 64'd1);
    RST_N = 1'b0;
    @(negedge CLK);
    checkOutput("run4_rst_busy", 64'(busy), 64'd0);
    checkOutput("run4_rst_done", 64'(done), 64'd0);
    checkOutput("run4_rst_vec_valid", 64'(vec_valid), 64'd0);
    checkOutput("run4_rst_pass", 64'(pass_cnt), 64'd0);
    checkOutput("run4_rst_fail", 64'(fail_cnt), 64'd0);
    checkOutput("run4_rst_vec_base", vec_base, 64'd0);
    check_vectors("run4", off4, 11);
    exp_q.delete();
    RST_N = 1'b1;
    mdl_lfsr = SEED;
    off5 = got_q.size();
    push_run_expect();
    applyStimulus();
    wait_done(500);
    @(negedge CLK);
    checkOutput("run5_count", 64'(got_q.size() - off5), 64'd12);
    check_vectors("run5", off5, 12);
    checkOutput("run5_pass", 64'(pass_cnt), 64'd12);
    checkOutput("run5_fail", 64'(fail_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
